// File: rtl/bcd_to_binary_seq.sv
// Sequential six-digit BCD to 17-bit binary converter using Horner accumulation,
// one digit per clock, with a range/validity check and the decimal length of the result.
module bcd_to_binary_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  in100000,
  input  logic [3:0]  in10000,
  input  logic [3:0]  in1000,
  input  logic [3:0]  in100,
  input  logic [3:0]  in10,
  input  logic [3:0]  in1,
  output logic        busy,
  output logic        done,
  output logic [16:0] value,
  output logic [2:0]  len,
  output logic        error
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [20:0] MAX_VALUE = 21'd131071;

  state_t      state;
  state_t      state_next;
  logic [3:0]  digit_q [6];
  logic [20:0] acc;
  logic [20:0] acc_next;
  logic [2:0]  step;
  logic        bad;
  logic        bad_next;
  logic [3:0]  cur_digit;
  logic        last_step;
  logic        result_ok;
  logic [2:0]  len_next;
  logic        capture;

  assign capture   = (state == IDLE) && start;
  assign last_step = (state == RUN) && (step == 3'd5);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)     state_next = RUN;
      RUN:  if (last_step) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Output logic: busy decodes directly from the state flop, so it is glitch-free.
  always_comb begin
    busy = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Digit select; step never exceeds 5 while running.
  always_comb begin
    cur_digit = 4'd0;
    case (step)
      3'd0:    cur_digit = digit_q[0];
      3'd1:    cur_digit = digit_q[1];
      3'd2:    cur_digit = digit_q[2];
      3'd3:    cur_digit = digit_q[3];
      3'd4:    cur_digit = digit_q[4];
      3'd5:    cur_digit = digit_q[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // acc*10 as shift-add; 21 bits hold 15*111111 without wrapping.
  assign acc_next  = (acc << 3) + (acc << 1) + {17'd0, cur_digit};
  assign bad_next  = bad || (cur_digit > 4'd9);
  assign result_ok = !bad_next && (acc_next <= MAX_VALUE);

  // Decimal length of the final accumulation, leading zeros not counted.
  always_comb begin
    len_next = 3'd1;
    if      (acc_next >= 21'd100000) len_next = 3'd6;
    else if (acc_next >= 21'd10000)  len_next = 3'd5;
    else if (acc_next >= 21'd1000)   len_next = 3'd4;
    else if (acc_next >= 21'd100)    len_next = 3'd3;
    else if (acc_next >= 21'd10)     len_next = 3'd2;
    else                             len_next = 3'd1;
  end

  // Datapath and result registers.
  // NOTE: the six-entry digit store is reset along with everything else; it is
  // tiny, and a defined value keeps simulation free of X on an early read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) digit_q[i] <= 4'd0;
      acc   <= '0;
      bad   <= 1'b0;
      step  <= 3'd0;
      done  <= 1'b0;
      value <= '0;
      len   <= 3'd1;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        digit_q[0] <= in100000;
        digit_q[1] <= in10000;
        digit_q[2] <= in1000;
        digit_q[3] <= in100;
        digit_q[4] <= in10;
        digit_q[5] <= in1;
        acc        <= '0;
        bad        <= 1'b0;
        step       <= 3'd0;
      end else if (state == RUN) begin
        acc  <= acc_next;
        bad  <= bad_next;
        step <= last_step ? 3'd0 : step + 3'd1;
        if (last_step) begin
          done <= 1'b1;
          if (result_ok) begin
            value <= acc_next[16:0];
            len   <= len_next;
            error <= 1'b0;
          end else begin
            // Invalid result leaves the previous value/len visible.
            error <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases plus randomized
// round trips through an arithmetic forward splitter and reference model.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  din [6];
  logic        busy;
  logic        done;
  logic [16:0] value;
  logic [2:0]  len;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what value/len/error should currently show.
  int exp_value = 0;
  int exp_len   = 1;
  int exp_error = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in100000 (din[0]),
    .in10000  (din[1]),
    .in1000   (din[2]),
    .in100    (din[3]),
    .in10     (din[4]),
    .in1      (din[5]),
    .busy     (busy),
    .done     (done),
    .value    (value),
    .len      (len),
    .error    (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dec_len(input int x);
    int n = 1;
    int t = x;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  task automatic split(input int v, output logic [3:0] d [6]);
    int t = v;
    for (int i = 5; i >= 0; i--) begin
      d[i] = 4'(t % 10);
      t = t / 10;
    end
  endtask

  // Reference model: decimal weighting of the six digits, then the range rule.
  task automatic model_update(input logic [3:0] d [6]);
    int total = 0;
    bit bad = 0;
    for (int i = 0; i < 6; i++) begin
      total = total * 10 + int'(d[i]);
      if (d[i] > 4'd9) bad = 1;
    end
    if (bad || total > 131071) begin
      exp_error = 1;
    end else begin
      exp_value = total;
      exp_len   = dec_len(total);
      exp_error = 0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_value"}, 32'(value), 32'(exp_value));
    check({tag, "_len"},   32'(len),   32'(exp_len));
    check({tag, "_error"}, 32'(error), 32'(exp_error));
  endtask

  // One conversion with a single-cycle start; digits scrambled after capture.
  task automatic run_conv(input string tag, input logic [3:0] d [6], input bit full);
    int lat = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) din[i] = d[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(15, 0));
    while (!done && lat < 20) begin
      if (full) check({tag, "_busy_run"}, 32'(busy), 32'd1);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
    model_update(d);
    if (full) check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_outputs(tag);
    tick();
    if (full) check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [3:0] d [6];
    int v;
    int dones;
    int guard;

    for (int i = 0; i < 6; i++) din[i] = 4'd0;

    // Reset state.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic conversion.
    d = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    run_conv("basic", d, 1);

    // Bounds.
    d = '{4'd1, 4'd3, 4'd1, 4'd0, 4'd7, 4'd1};
    run_conv("max", d, 1);
    d = '{4'd1, 4'd3, 4'd1, 4'd0, 4'd7, 4'd2};
    run_conv("max_plus1", d, 1);
    d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_conv("zero", d, 1);

    // Invalid digit and overflow.
    d = '{4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0};
    run_conv("bad_digit", d, 1);
    d = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    run_conv("overflow", d, 1);
    d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
    run_conv("single", d, 1);

    // Handshake: start held high, digits scrambled while busy.
    @(negedge clk);
    d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
    for (int i = 0; i < 6; i++) din[i] = d[i];
    start = 1'b1;
    dones = 0;
    for (int c = 0; c < 31; c++) begin
      tick();
      if (done) begin
        dones++;
        check("hs_value", 32'(value), 32'd42);
        check("hs_len",   32'(len),   32'd2);
        check("hs_error", 32'(error), 32'd0);
        for (int i = 0; i < 6; i++) din[i] = d[i];
        tick();
        c++;
        check("hs_rebusy", 32'(busy), 32'd1);
      end
      for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(15, 0));
    end
    start = 1'b0;
    check("hs_count_in_range", 32'((dones >= 4) && (dones <= 5)), 32'd1);
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      guard++;
    end
    check("hs_drain", 32'(busy), 32'd0);
    // The drained run captured scrambled digits; the model follows whatever
    // the last completion reported only via a fresh known conversion.
    tick();
    d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
    run_conv("hs_after", d, 1);

    // Reset mid-run: no done, outputs back to reset values.
    @(negedge clk);
    d = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    for (int i = 0; i < 6; i++) din[i] = d[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    exp_value = 0;
    exp_len   = 1;
    exp_error = 0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check_outputs("midrst_after");
    run_conv("post_rst", d, 1);

    // Fully random digits, including invalid codes.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 6; i++) d[i] = 4'($urandom_range(15, 0));
      run_conv("rand_digits", d, 1);
    end

    // Round trip through the forward splitter.
    for (int n = 0; n < 4000; n++) begin
      v = int'($urandom_range(131071, 0));
      split(v, d);
      run_conv("roundtrip", d, 0);
      check("rt_value", 32'(value), 32'(v));
      check("rt_len",   32'(len),   32'(dec_len(v)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
